// File: rtl/ray_dispatcher_pkg.sv
// Shared types and constants for the ray dispatcher: ray vector layout, colours, FSM states.
package ray_dispatcher_pkg;
  localparam int RAY_W   = 28;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int Z_W     = 9;
  localparam int X_LSB   = 18;
  localparam int Y_LSB   = 9;
  localparam int Z_LSB   = 0;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 19;

  localparam logic [COLOR_W-1:0] BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;

  // Field order matches X_LSB/Y_LSB/Z_LSB when cast to a 28-bit vector.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [Z_W-1:0] z;
  } ray_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_WRITE, ST_ADVANCE, ST_DONE
  } state_t;

  function automatic ray_vec_t pack_ray(input logic [X_W-1:0] x,
                                        input logic [Y_W-1:0] y,
                                        input logic [Z_W-1:0] z);
    ray_vec_t r;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction
endpackage

// File: rtl/ray_dispatcher_pixel_counter.sv
// Raster scan position: x/y plus a linear frame-buffer address kept in step by increment.
module ray_pixel_counter
  import ray_dispatcher_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic x_end, y_end;

  assign x_end = (x == X_W'(H_RES - 1));
  assign y_end = (y == Y_W'(V_RES - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (adv) begin
      if (x_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
      addr <= addr + 1'b1;
    end
  end
endmodule

// File: rtl/ray_dispatcher.sv
// Per-pixel primary-ray dispatcher: issue ray, await tracer, write colour to frame buffer.
// Optional RAY_TIMEOUT_EN bounds the tracer wait and writes black on expiry.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int EYE_X    = 320,
  parameter int EYE_Y    = 240,
  parameter int EYE_Z    = 0,
  parameter int SCREEN_Z = 256
`ifdef RAY_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 1023
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [RAY_W-1:0]   init,
  output logic [RAY_W-1:0]   dir,
  output logic               ray_valid,
  input  logic               tracer_ret,
  input  logic [COLOR_W-1:0] color_in,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               frame_done
);
  state_t          state, state_nxt;
  logic            cnt_clr, cnt_adv, last;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  ray_vec_t        init_q, dir_q;
  logic            timeout;

  ray_pixel_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .x    (x),
    .y    (y),
    .addr (fb_addr),
    .last (last)
  );

`ifdef RAY_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] wcnt;

  // Counter holds k-1 in the k-th WAIT cycle, so expiry lands on WAIT cycle TIMEOUT.
  assign timeout = (wcnt == WCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state == ST_ISSUE) wcnt <= '0;
    else if (state == ST_WAIT)       wcnt <= wcnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      ST_IDLE:    if (start) begin
                    state_nxt = ST_ISSUE;
                    cnt_clr   = 1'b1;
                  end
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (tracer_ret || timeout) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = ST_ADVANCE;
      ST_ADVANCE: if (last) state_nxt = ST_DONE;
                  else begin
                    state_nxt = ST_ISSUE;
                    cnt_adv   = 1'b1;
                  end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      init_q    <= '0;
      dir_q     <= '0;
      ray_valid <= 1'b0;
      fb_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_ISSUE) begin
        init_q    <= pack_ray(X_W'(EYE_X), Y_W'(EYE_Y), Z_W'(EYE_Z));
        dir_q     <= pack_ray(x - X_W'(EYE_X), y - Y_W'(EYE_Y), Z_W'(SCREEN_Z - EYE_Z));
        ray_valid <= 1'b1;
      end
      // A return coinciding with expiry still delivers its colour.
      if (state == ST_WAIT && tracer_ret) begin
        fb_data   <= color_in;
        ray_valid <= 1'b0;
      end else if (state == ST_WAIT && timeout) begin
        fb_data   <= BLACK;
        ray_valid <= 1'b0;
      end
      if (state == ST_IDLE && start) busy <= 1'b1;
      else if (state == ST_DONE)     busy <= 1'b0;
    end
  end

  assign init       = init_q;
  assign dir        = dir_q;
  assign fb_we      = (state == ST_WRITE);
  assign frame_done = (state == ST_DONE);
endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher on a 4x2 screen with a behavioural tracer.
module tb_ray_dispatcher;
  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;
  localparam logic [27:0] INIT_EXP = 28'h501E000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] init, dir;
  logic        ray_valid;
  logic        tracer_ret = 1'b0;
  logic [11:0] color_in = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        busy, frame_done;

  ray_dispatcher #(
    .H_RES(H), .V_RES(V)
`ifdef RAY_TIMEOUT_EN
    , .TIMEOUT(5)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init), .dir(dir),
    .ray_valid(ray_valid), .tracer_ret(tracer_ret), .color_in(color_in),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [18:0] addr; logic [11:0] data; } wr_t;
  typedef struct { logic [27:0] init; logic [27:0] dir; } ray_t;
  wr_t  wq[$];
  ray_t rq[$];
  logic [27:0] dir_log[$];

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, ray_total = 0, wr_total = 0, unstable = 0;
  logic busy_at_done = 1'b0;

  logic [11:0] col_base = '0;
  int          ret_delay = 0;
  logic        force_ret = 1'b0;
  logic [11:0] force_col = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [27:0] exp_dir(input int i);
    logic [9:0] dx;
    logic [8:0] dy;
    logic [8:0] dz;
    dx = 10'(i % H - 320);
    dy = 9'(i / H - 240);
    dz = 9'(256);
    return {dx, dy, dz};
  endfunction

  function automatic logic [11:0] exp_col(input int i, input logic [11:0] c, input bit black);
    logic [5:0] xs, ys;
    xs = 6'(i % H);
    ys = 6'(i / H);
    return black ? 12'h000 : (c ^ {xs, ys});
  endfunction

  always @(posedge clk) cyc++;

  // Tracer model: answers after ret_delay WAIT cycles with a colour derived from the ray.
  int tr_wait = 0;
  always @(negedge clk) begin
    logic [9:0] px;
    logic [8:0] py;
    if (ray_valid) begin
      px = dir[27:18] + 10'd320;
      py = dir[17:9] + 9'd240;
      if (tr_wait >= ret_delay) begin
        tracer_ret = 1'b1;
        color_in   = col_base ^ {px[5:0], py[5:0]};
      end else begin
        tracer_ret = 1'b0;
      end
      tr_wait++;
    end else begin
      tr_wait    = 0;
      tracer_ret = force_ret;
      color_in   = force_col;
    end
  end

  // Monitor: compares rays and writes against the scoreboard queues.
  logic        prev_rv = 1'b0;
  logic [27:0] last_init = '0, last_dir = '0;
  always @(negedge clk) begin
    ray_t r;
    wr_t  w;
    if (ray_valid && !prev_rv) begin
      ray_total++;
      dir_log.push_back(dir);
      if (rq.size() == 0) chk("unexpected_ray", 1, 0);
      else begin
        r = rq.pop_front();
        chk("ray_init", init, r.init);
        chk("ray_dir", dir, r.dir);
      end
    end else if (ray_valid && (init != last_init || dir != last_dir)) begin
      unstable++;
    end
    prev_rv   = ray_valid;
    last_init = init;
    last_dir  = dir;
    if (fb_we) begin
      wr_total++;
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", fb_addr, w.addr);
        chk("wr_data", fb_data, w.data);
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic push_frame(input logic [11:0] c, input bit black);
    for (int i = 0; i < N; i++) begin
      wq.push_back('{addr: 19'(i), data: exp_col(i, c, black)});
      rq.push_back('{init: INIT_EXP, dir: exp_dir(i)});
    end
  endtask

  task automatic run_frame(input logic [11:0] c, input int dly, input bit black,
                           input bit extra_start, input int exp_len);
    int d0, acc, n;
    col_base  = c;
    ret_delay = dly;
    push_frame(c, black);
    d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (extra_start) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", n < 3000, 1);
    if (exp_len > 0) chk("frame_length", done_cyc - acc + 1, exp_len);
    chk("busy_in_done", busy_at_done, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
  endtask

  initial begin
    int base, n, w0, u0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {init, dir, ray_valid, fb_we, fb_addr, fb_data, frame_done}, '0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First frame: white returns, immediate tracer; also covers the 4x2 line wrap.
    base = ray_total;
    run_frame(12'hFFF, 0, 1'b0, 1'b0, 4 * N + 1);
    chk("first_dir", dir_log[base], 28'hB022100);
    chk("pixel4_dir", dir_log[base + 4], 28'hB022300);

    // Stray return in IDLE must not write.
    w0 = wr_total;
    force_col = 12'hABC;
    force_ret = 1'b1;
    repeat (3) @(negedge clk);
    force_ret = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ret_no_write", wr_total - w0, 0);

    // Start pulsed while busy is ignored.
    run_frame(12'h5A5, 0, 1'b0, 1'b1, 4 * N + 1);
    repeat (3) @(negedge clk);
    chk("no_restart", busy, 0);

    // Delayed return: ray held stable through a 20-cycle wait.
    u0 = unstable;
    run_frame(12'h3C3, 20, 1'b0, 1'b0, 0);
    chk("stable_in_wait", unstable - u0, 0);

    // Mid-frame reset during the WAIT of pixel 2.
    base = ray_total;
    col_base  = 12'h111;
    ret_delay = 10;
    push_frame(12'h111, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (ray_total < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pixel2_issued", n < 500, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_outputs", {init, dir, ray_valid, fb_we, fb_addr, fb_data, busy, frame_done}, '0);
    chk("midreset_writes_left", wq.size(), N - 2);
    rst_n = 1'b1;
    wq.delete();
    rq.delete();
    n = done_cnt;
    repeat (5) @(negedge clk);
    chk("midreset_no_done", done_cnt - n, 0);
    run_frame(12'h777, 0, 1'b0, 1'b0, 4 * N + 1);

`ifdef RAY_TIMEOUT_EN
    // Silent tracer: every pixel times out to black after 5 WAIT cycles.
    run_frame(12'h123, 100000, 1'b1, 1'b0, 8 * N + 1);
    // Return on the 5th WAIT cycle coincides with expiry and wins.
    run_frame(12'hABC, 4, 1'b0, 1'b0, 8 * N + 1);
    // Return one cycle late loses to the timeout.
    run_frame(12'hABC, 5, 1'b1, 1'b0, 8 * N + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
endmodule
